// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
// Bundles the PS/2 line inputs and the decoded-key outputs of ps2_key_decoder.
//   PS2C, PS2D : raw PS/2 clock/data lines (asynchronous to clk)
//   ascii      : ASCII of the currently held mapped key, 8'h00 when none
//   key_valid  : one-cycle pulse per accepted mapped make code
//   scan_code  : last correctly framed byte
//   frame_err  : one-cycle pulse per discarded frame
// Modports: master = line driver / output consumer, slave = decoder.
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
    logic       PS2C;
    logic       PS2D;
    logic [7:0] ascii;
    logic       key_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    modport master (
        output PS2C, PS2D,
        input  ascii, key_valid, scan_code, frame_err
    );

    modport slave (
        input  PS2C, PS2D,
        output ascii, key_valid, scan_code, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Receives PS/2 keyboard frames (start, 8 data LSB first, parity, stop),
// tracks F0 (break) / E0 (extended) prefixes and maps a small set of make
// codes (w a s d q e space) to ASCII.
// Ports:
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : ps2_key_decoder_if.slave (PS2C, PS2D in; ascii, key_valid,
//          scan_code, frame_err out, all registered)
// Parameters:
//   FILTER_DEPTH   : consecutive equal samples needed to accept a PS2C level
//   TIMEOUT_CYCLES : idle clk cycles inside a frame before it is discarded
// Optional feature macro: PS2_PARITY_CHECK_EN enables odd-parity checking;
// without it the parity bit is sampled and ignored.
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int FILTER_DEPTH   = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    ps2_key_decoder_if.slave   bus
);

    localparam int FC_W = $clog2(FILTER_DEPTH + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FC_W-1:0] FILT_MAX = FC_W'(FILTER_DEPTH - 1);
    localparam logic [TW-1:0]   TO_MAX   = TW'(TIMEOUT_CYCLES);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when data bits plus parity bit contain an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Returns {hit, ascii} for the supported make codes.
    function automatic logic [8:0] ascii_map(input logic [7:0] code);
        logic [8:0] res;
        case (code)
            8'h1D:   res = {1'b1, 8'h77};
            8'h1C:   res = {1'b1, 8'h61};
            8'h1B:   res = {1'b1, 8'h73};
            8'h23:   res = {1'b1, 8'h64};
            8'h15:   res = {1'b1, 8'h71};
            8'h24:   res = {1'b1, 8'h65};
            8'h29:   res = {1'b1, 8'h20};
            default: res = {1'b0, 8'h00};
        endcase
        return res;
    endfunction

    logic            ps2c_meta_r, ps2c_sync_r, ps2d_meta_r, ps2d_sync_r;
    logic            ps2c_filt_r;
    logic [FC_W-1:0] filt_cnt_r;
    logic            fall_r;

    state_t          state_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      shift_r;
    logic            parity_r;
    logic [TW-1:0]   to_cnt_r;
    logic            brk_r, ext_r;
    logic [7:0]      ascii_r, scan_code_r;
    logic            key_valid_r, frame_err_r;

    logic [8:0]      map_s;
    logic            par_ok_s;

    // Synchronize both lines and debounce PS2C; fall_r marks a filtered 1->0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2c_meta_r <= 1'b1;
            ps2c_sync_r <= 1'b1;
            ps2d_meta_r <= 1'b1;
            ps2d_sync_r <= 1'b1;
            ps2c_filt_r <= 1'b1;
            filt_cnt_r  <= '0;
            fall_r      <= 1'b0;
        end else begin
            ps2c_meta_r <= bus.PS2C;
            ps2c_sync_r <= ps2c_meta_r;
            ps2d_meta_r <= bus.PS2D;
            ps2d_sync_r <= ps2d_meta_r;
            fall_r      <= 1'b0;
            if (ps2c_sync_r == ps2c_filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FILT_MAX) begin
                // FILTER_DEPTH-th consecutive differing sample: accept new level
                ps2c_filt_r <= ps2c_sync_r;
                filt_cnt_r  <= '0;
                fall_r      <= ~ps2c_sync_r;
            end else begin
                filt_cnt_r <= filt_cnt_r + FC_W'(1);
            end
        end
    end

    // Lookup of the assembled byte and parity verdict (forced good when disabled).
    always_comb begin
        map_s    = ascii_map(shift_r);
        par_ok_s = odd_parity_ok(shift_r, parity_r) | ~PARITY_EN;
    end

    // Frame receiver FSM with timeout, prefix tracking and key decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            parity_r    <= 1'b0;
            to_cnt_r    <= '0;
            brk_r       <= 1'b0;
            ext_r       <= 1'b0;
            ascii_r     <= 8'h00;
            scan_code_r <= 8'h00;
            key_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (state_r == ST_IDLE || fall_r) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (fall_r && !ps2d_sync_r) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 3'd0;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (fall_r) begin
                        shift_r <= {ps2d_sync_r, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else if (to_cnt_r == TO_MAX) begin
                        state_r     <= ST_IDLE;
                        frame_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (fall_r) begin
                        parity_r <= ps2d_sync_r;
                        state_r  <= ST_STOP;
                    end else if (to_cnt_r == TO_MAX) begin
                        state_r     <= ST_IDLE;
                        frame_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (fall_r) begin
                        state_r <= ST_IDLE;
                        if (ps2d_sync_r && par_ok_s) begin
                            scan_code_r <= shift_r;
                            if (shift_r == 8'hF0) begin
                                brk_r <= 1'b1;
                            end else if (shift_r == 8'hE0) begin
                                ext_r <= 1'b1;
                            end else begin
                                brk_r <= 1'b0;
                                ext_r <= 1'b0;
                                if (brk_r) begin
                                    // Release only clears if it is the key on display
                                    if (map_s[8] && !ext_r && map_s[7:0] == ascii_r) begin
                                        ascii_r <= 8'h00;
                                    end else begin
                                        ascii_r <= ascii_r;
                                    end
                                end else if (map_s[8] && !ext_r) begin
                                    ascii_r     <= map_s[7:0];
                                    key_valid_r <= 1'b1;
                                end else begin
                                    ascii_r <= ascii_r;
                                end
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end else if (to_cnt_r == TO_MAX) begin
                        state_r     <= ST_IDLE;
                        frame_err_r <= 1'b1;
                    end else begin
                        state_r <= ST_STOP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ascii     = ascii_r;
    assign bus.key_valid = key_valid_r;
    assign bus.scan_code = scan_code_r;
    assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Directed PS/2 frames with hand-computed expectations pushed into a queue;
// a monitor pops and compares whenever the decoder shows an output event
// (key_valid, frame_err, or a change in ascii/scan_code).
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

    localparam int HALF    = 20;
    localparam int GAP     = 100;
    localparam int TIMEOUT = 300;

    typedef struct packed {
        logic       kv;
        logic       fe;
        logic [7:0] a;
        logic [7:0] s;
    } exp_t;

    logic clk;
    logic rst;
    ps2_key_decoder_if bus_if();

    ps2_key_decoder #(
        .FILTER_DEPTH   (8),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t       q[$];
    int         tests;
    int         fails;
    logic       mon_en;
    logic [7:0] prev_ascii, prev_scan;
    logic       prev_kv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic kv, input logic fe, input logic [7:0] a, input logic [7:0] s);
        exp_t e;
        e.kv = kv; e.fe = fe; e.a = a; e.s = s;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        bus_if.PS2D = b;
        repeat (HALF) @(posedge clk);
        #1 bus_if.PS2C = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 bus_if.PS2C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_good ? ~^b : ^b);
        send_bit(stop_bit);
        bus_if.PS2D = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    // Monitor: every output event consumes one expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.key_valid) begin
                tests++;
                if (prev_kv) begin
                    fails++;
                    $display("FAIL kv_width: key_valid high %0d cycles, required 1", 2);
                end
            end
            if (bus_if.key_valid || bus_if.frame_err ||
                bus_if.ascii != prev_ascii || bus_if.scan_code != prev_scan) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL event: unexpected kv=%0b fe=%0b ascii=%h scan=%h, required none",
                             bus_if.key_valid, bus_if.frame_err, bus_if.ascii, bus_if.scan_code);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({bus_if.key_valid, bus_if.frame_err, bus_if.ascii, bus_if.scan_code} !== e) begin
                        fails++;
                        $display("FAIL event: got kv=%0b fe=%0b ascii=%h scan=%h, required kv=%0b fe=%0b ascii=%h scan=%h",
                                 bus_if.key_valid, bus_if.frame_err, bus_if.ascii, bus_if.scan_code,
                                 e.kv, e.fe, e.a, e.s);
                    end
                end
            end
            prev_ascii = bus_if.ascii;
            prev_scan  = bus_if.scan_code;
            prev_kv    = bus_if.key_valid;
        end
    end

    initial begin
        logic [7:0] a_after_par;
        tests = 0; fails = 0; mon_en = 1'b0;
        prev_ascii = 8'h00; prev_scan = 8'h00; prev_kv = 1'b0;
        rst = 1'b0;
        bus_if.PS2C = 1'b1;
        bus_if.PS2D = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus_if.ascii, bus_if.scan_code, bus_if.key_valid, bus_if.frame_err} !== 18'h0) begin
            fails++;
            $display("FAIL reset: ascii=%h scan=%h kv=%0b fe=%0b, required all 0",
                     bus_if.ascii, bus_if.scan_code, bus_if.key_valid, bus_if.frame_err);
        end
        @(posedge clk); #1 rst = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(posedge clk);

        // w press / release
        push(1'b1, 1'b0, 8'h77, 8'h1D); send_frame(8'h1D, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'h77, 8'hF0); send_frame(8'hF0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'h00, 8'h1D); send_frame(8'h1D, 1'b1, 1'b1);
        // a held, release of w ignored
        push(1'b1, 1'b0, 8'h61, 8'h1C); send_frame(8'h1C, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'h61, 8'hF0); send_frame(8'hF0, 1'b1, 1'b1);
        push(1'b0, 1'b0, 8'h61, 8'h1D); send_frame(8'h1D, 1'b1, 1'b1);
        // typematic repeat, then last key wins
        push(1'b1, 1'b0, 8'h61, 8'h1C); send_frame(8'h1C, 1'b1, 1'b1);
        push(1'b1, 1'b0, 8'h73, 8'h1B); send_frame(8'h1B, 1'b1, 1'b1);
        // bad stop bit
        push(1'b0, 1'b1, 8'h73, 8'h1B); send_frame(8'h23, 1'b1, 1'b0);
        // truncated frame: start + 4 data bits, then idle past timeout
        push(1'b0, 1'b1, 8'h73, 8'h1B);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        bus_if.PS2D = 1'b1;
        repeat (TIMEOUT + 100) @(posedge clk);
        push(1'b1, 1'b0, 8'h20, 8'h29); send_frame(8'h29, 1'b1, 1'b1);
        // even parity on 'e'
`ifdef PS2_PARITY_CHECK_EN
        push(1'b0, 1'b1, 8'h20, 8'h29); a_after_par = 8'h20;
`else
        push(1'b1, 1'b0, 8'h65, 8'h24); a_after_par = 8'h65;
`endif
        send_frame(8'h24, 1'b0, 1'b1);
        // extended make of a mapped code does nothing but update scan_code
        push(1'b0, 1'b0, a_after_par, 8'hE0); send_frame(8'hE0, 1'b1, 1'b1);
        push(1'b0, 1'b0, a_after_par, 8'h15); send_frame(8'h15, 1'b1, 1'b1);
        push(1'b1, 1'b0, 8'h71, 8'h15);       send_frame(8'h15, 1'b1, 1'b1);
        // unmapped code
        push(1'b0, 1'b0, 8'h71, 8'h5A);       send_frame(8'h5A, 1'b1, 1'b1);
        // short PS2C glitch with data low must not start a frame
        bus_if.PS2D = 1'b0;
        #1 bus_if.PS2C = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus_if.PS2C = 1'b1;
        bus_if.PS2D = 1'b1;
        repeat (50) @(posedge clk);
        push(1'b1, 1'b0, 8'h77, 8'h1D);       send_frame(8'h1D, 1'b1, 1'b1);

        // bounded drain of the scoreboard
        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected events outstanding, required 0", q.size());
        end
        repeat (50) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
